// File: rtl/pipe_skid_stage.sv
// ============================================================================
// Module   : pipe_skid_stage
// Brief    : Flushable valid/ready pipeline register with a two-entry skid
//            buffer, bubble injection and a saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_stage #(
   parameter int            DW     = 32,
   parameter logic [DW-1:0] BUBBLE = {DW{1'b0}},
   parameter int            CW     = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic [DW-1:0] in_data_i,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [DW-1:0] out_data_o,
   output logic [1:0]    occ_o,
   output logic [CW-1:0] stall_cnt_o
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   localparam logic [CW-1:0] c_STALL_MAX = {CW{1'b1}};

   state_t          r_state;
   logic            r_main_v;
   logic            r_skid_v;
   logic            r_in_ready;
   logic [DW-1:0]   r_main_d;
   logic [DW-1:0]   r_skid_d;
   logic [CW-1:0]   r_stall_cnt;

   logic            w_in_fire;
   logic            w_out_fire;

   assign w_in_fire  = in_valid_i & r_in_ready;
   assign w_out_fire = r_main_v & out_ready_i;

   // Ready is a flop so downstream back-pressure never reaches upstream combinationally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_EMPTY;
         r_main_v   <= 1'b0;
         r_skid_v   <= 1'b0;
         r_in_ready <= 1'b1;
         r_main_d   <= BUBBLE;
         r_skid_d   <= BUBBLE;
      end else if (flush_i) begin
         r_state    <= S_EMPTY;
         r_main_v   <= 1'b0;
         r_skid_v   <= 1'b0;
         r_in_ready <= 1'b1;
         r_main_d   <= BUBBLE;
         r_skid_d   <= BUBBLE;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_in_fire) begin
                  r_state  <= S_ONE;
                  r_main_v <= 1'b1;
                  r_main_d <= in_data_i;
               end
            end
            S_ONE: begin
               if (w_in_fire && w_out_fire) begin
                  r_main_d <= in_data_i;
               end else if (w_in_fire) begin
                  r_state    <= S_FULL;
                  r_skid_v   <= 1'b1;
                  r_in_ready <= 1'b0;
                  r_skid_d   <= in_data_i;
               end else if (w_out_fire) begin
                  r_state  <= S_EMPTY;
                  r_main_v <= 1'b0;
                  r_main_d <= BUBBLE;
               end
            end
            S_FULL: begin
               if (w_out_fire) begin
                  r_state    <= S_ONE;
                  r_skid_v   <= 1'b0;
                  r_in_ready <= 1'b1;
                  r_main_d   <= r_skid_d;
                  r_skid_d   <= BUBBLE;
               end
            end
            default: begin
               r_state    <= S_EMPTY;
               r_main_v   <= 1'b0;
               r_skid_v   <= 1'b0;
               r_in_ready <= 1'b1;
               r_main_d   <= BUBBLE;
               r_skid_d   <= BUBBLE;
            end
         endcase
      end
   end

   // Counts every cycle a live payload is refused; flush deliberately leaves it alone.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
      end else if (r_main_v && !out_ready_i && (r_stall_cnt != c_STALL_MAX)) begin
         r_stall_cnt <= r_stall_cnt + CW'(1);
      end
   end

   assign in_ready_o  = r_in_ready;
   assign out_valid_o = r_main_v;
   assign out_data_o  = r_main_d;
   assign occ_o       = {1'b0, r_main_v} + {1'b0, r_skid_v};
   assign stall_cnt_o = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
// ============================================================================
// Module   : tb_pipe_skid_stage
// Brief    : Self-checking bench for pipe_skid_stage (directed table plus
//            randomized traffic against a queue reference model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_skid_stage;

   localparam logic [31:0] c_BUBBLE = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;

   logic        in_ready,  in_ready4;
   logic        out_valid, out_valid4;
   logic [31:0] out_data,  out_data4;
   logic [1:0]  occ,       occ4;
   logic [15:0] stall;
   logic [3:0]  stall4;

   pipe_skid_stage #(.DW(32), .BUBBLE(c_BUBBLE), .CW(16)) dut (
      .clk(clk), .rst(rst), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
      .occ_o(occ), .stall_cnt_o(stall)
   );

   pipe_skid_stage #(.DW(32), .BUBBLE(c_BUBBLE), .CW(4)) dut4 (
      .clk(clk), .rst(rst), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(in_ready4), .in_data_i(in_data),
      .out_valid_o(out_valid4), .out_ready_i(out_ready), .out_data_o(out_data4),
      .occ_o(occ4), .stall_cnt_o(stall4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference: a bounded FIFO of live payloads plus two saturating counters.
   logic [31:0] mq[$];
   int          m_stall;
   int          m_stall4;
   bit          seen33;

   typedef struct {
      logic        v;
      logic [31:0] d;
      logic        ordy;
      logic        fl;
      logic        e_valid;
      logic [31:0] e_data;
      logic [1:0]  e_occ;
      logic        e_ready;
      logic [15:0] e_stall;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_stall  = 0;
      m_stall4 = 0;
   endtask

   task automatic model_edge();
      bit can_take;
      bit can_give;
      can_take = in_valid && (mq.size() < 2);
      can_give = (mq.size() > 0) && out_ready;
      if ((mq.size() > 0) && !out_ready) begin
         if (m_stall < 65535) m_stall++;
         if (m_stall4 < 15)   m_stall4++;
      end
      if (flush) begin
         mq.delete();
      end else begin
         if (can_give) void'(mq.pop_front());
         if (can_take) mq.push_back(in_data);
      end
   endtask

   task automatic check_model(input string tag);
      logic [31:0] exp_d;
      exp_d = (mq.size() > 0) ? mq[0] : c_BUBBLE;
      chk({tag, ".valid"},  32'(out_valid), 32'(mq.size() > 0));
      chk({tag, ".data"},   out_data, exp_d);
      chk({tag, ".ready"},  32'(in_ready), 32'(mq.size() < 2));
      chk({tag, ".occ"},    32'(occ), 32'(mq.size()));
      chk({tag, ".stall"},  32'(stall), 32'(m_stall));
      chk({tag, ".data4"},  out_data4, exp_d);
      chk({tag, ".stall4"}, 32'(stall4), 32'(m_stall4));
   endtask

   task automatic cycle(input logic v, input logic [31:0] d, input logic ordy, input logic fl,
                        input string tag);
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      model_edge();
      #1;
      if (out_data == 32'h33) seen33 = 1'b1;
      check_model(tag);
   endtask

   task automatic add(input logic v, input logic [31:0] d, input logic ordy, input logic fl,
                      input logic ev, input logic [31:0] ed, input logic [1:0] eo,
                      input logic er, input logic [15:0] es);
      vec_t r;
      r.v = v; r.d = d; r.ordy = ordy; r.fl = fl;
      r.e_valid = ev; r.e_data = ed; r.e_occ = eo; r.e_ready = er; r.e_stall = es;
      tbl.push_back(r);
   endtask

   initial begin
      // Streaming 1..16, then drain.
      for (int i = 1; i <= 16; i++) add(1, 32'(i), 1, 0, 1, 32'(i), 2'd1, 1, 16'd0);
      add(0, 0, 1, 0, 0, c_BUBBLE, 2'd0, 1, 16'd0);
      // Back-pressure: A shown, then ready low for 5 cycles, then release.
      add(1, 32'hA, 1, 0, 1, 32'hA, 2'd1, 1, 16'd0);
      add(1, 32'hB, 0, 0, 1, 32'hA, 2'd2, 0, 16'd1);
      for (int i = 2; i <= 5; i++) add(1, 32'hC, 0, 0, 1, 32'hA, 2'd2, 0, 16'(i));
      add(1, 32'hC, 1, 0, 1, 32'hB, 2'd1, 1, 16'd5);
      add(1, 32'hC, 1, 0, 1, 32'hC, 2'd1, 1, 16'd5);
      add(0, 0,     1, 0, 0, c_BUBBLE, 2'd0, 1, 16'd5);
      // Flush while FULL with a competing upstream payload.
      add(1, 32'h11, 0, 0, 1, 32'h11, 2'd1, 1, 16'd5);
      add(1, 32'h22, 0, 0, 1, 32'h11, 2'd2, 0, 16'd6);
      add(1, 32'h33, 0, 1, 0, c_BUBBLE, 2'd0, 1, 16'd7);
      add(0, 0,      1, 0, 0, c_BUBBLE, 2'd0, 1, 16'd7);

      // Reset held with random inputs.
      rst = 1'b0; flush = 0; in_valid = 0; in_data = 0; out_ready = 0;
      seen33 = 1'b0;
      model_reset();
      for (int i = 0; i < 6; i++) begin
         in_valid  = 1'($urandom);
         in_data   = $urandom;
         out_ready = 1'($urandom);
         flush     = 1'($urandom);
         @(posedge clk);
         #1;
         chk("rst.data",  out_data, c_BUBBLE);
         chk("rst.valid", 32'(out_valid), 32'd0);
         chk("rst.ready", 32'(in_ready), 32'd1);
         chk("rst.occ",   32'(occ), 32'd0);
         chk("rst.stall", 32'(stall), 32'd0);
      end
      rst = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         string t;
         t = $sformatf("tbl%0d", i);
         cycle(tbl[i].v, tbl[i].d, tbl[i].ordy, tbl[i].fl, t);
         chk({t, ".e_valid"}, 32'(out_valid), 32'(tbl[i].e_valid));
         chk({t, ".e_data"},  out_data, tbl[i].e_data);
         chk({t, ".e_occ"},   32'(occ), 32'(tbl[i].e_occ));
         chk({t, ".e_ready"}, 32'(in_ready), 32'(tbl[i].e_ready));
         chk({t, ".e_stall"}, 32'(stall), 32'(tbl[i].e_stall));
      end
      chk("flush.no33", 32'(seen33), 32'd0);

      // Asynchronous reset mid-operation, observed without any clock edge.
      cycle(1, 32'h44, 0, 0, "pre_rst");
      #2;
      rst = 1'b0;
      #1;
      chk("arst.valid", 32'(out_valid), 32'd0);
      chk("arst.data",  out_data, c_BUBBLE);
      chk("arst.occ",   32'(occ), 32'd0);
      chk("arst.ready", 32'(in_ready), 32'd1);
      chk("arst.stall", 32'(stall), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Saturation: one held payload refused for 20 cycles.
      cycle(1, 32'h55, 0, 0, "sat_load");
      for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, "sat");
      chk("sat.stall4", 32'(stall4), 32'd15);
      chk("sat.stall16", 32'(stall), 32'd20);
      cycle(0, 0, 0, 1, "sat_flush");
      chk("sat_flush.stall4", 32'(stall4), 32'd15);
      cycle(0, 0, 1, 0, "sat_after");
      chk("sat_after.stall4", 32'(stall4), 32'd15);

      // Random traffic against the reference model.
      for (int i = 0; i < 10000; i++) begin
         cycle(($urandom_range(3) != 0), $urandom, ($urandom_range(2) != 0),
               ($urandom_range(49) == 0), "rnd");
         chk("rnd.occ_bound", 32'(occ <= 2'd2), 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
